seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Downstream display stage for the cascaded decimal up/down counter digits. Captures DIGITS BCD digits into a shadow register and time-multiplexes them onto one 7-segment bus with per-digit anode strobes. It optionally blanks leading zeros. It stretches the counters' one-cycle sup (carry) / inf (borrow) pulses into visible decimal-point indications.

Parameters:
DIGITS, 4, number of BCD digits / anode lines (2..8)
PRESCALE, 1000, clk cycles each digit slot is displayed (>=2)
FLAG_HOLD, 64, full scan frames an overflow/underflow indication stays lit (>=1)
SEG_ACTIVE_LOW, 1, 1: seg/dp driven low = lit
AN_ACTIVE_LOW, 1, 1: an driven low = digit enabled

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  scan enable; 0 = display dark, scan frozen
latch  in  1  capture bcd_in into shadow register this cycle
bcd_in  in  4*DIGITS  digit i at [4i+3:4i], digit 0 = least significant
sup_in  in  1  carry pulse from counter chain (overflow)
inf_in  in  1  borrow pulse from counter chain (underflow)
blank_lz  in  1  leading-zero blanking enable
seg  out  7  segments, seg[0]=a .. seg[6]=g
dp  out  1  decimal point
an  out  DIGITS  one-hot anode select
frame_tick  out  1  1-cycle pulse when slot wraps DIGITS-1 -> 0

Behaviour:
- Reset (rst_n=0 at posedge): shadow=0, prescaler=0, slot=0, flags and hold counters=0, frame_tick=0. seg, dp and an all at inactive level.
- Shadow: latch=1 -> shadow<=bcd_in next edge, independent of en. The display never reads bcd_in directly.
- Prescaler: counts 0..PRESCALE-1 while en=1. At terminal count it returns to 0 and slot advances. Slot wraps DIGITS-1 -> 0 and pulses frame_tick in that same cycle. en=0: prescaler/slot hold, an/seg/dp inactive.
- Outputs are registered. an/seg/dp reflect the slot and shadow value of the previous cycle (1-cycle latency). A latch is visible on seg at most 2 cycles after the latch edge, in the current slot.
- Decode: 0-9 standard patterns (1 = b,c only; 7 = a,b,c). Codes 10-15 show "-" (g only).
- Leading-zero blanking (blank_lz=1): digit i>0 is blanked (its an inactive, seg inactive) if shadow digits i..DIGITS-1 are all 0. Digit 0 is never blanked, so value 0 shows a single "0".
- Overflow flag: sup_in=1 sets ovf and loads ovf_hold=FLAG_HOLD. ovf_hold decrements on each frame_tick; ovf clears when it reaches 0. A new sup_in pulse reloads the hold, including mid-hold.
- Underflow flag: inf_in does the same for udf / udf_hold.
- Simultaneous set and decrement: the reload wins. sup_in and inf_in in the same cycle set both flags.
- dp is lit when slot==0 and ovf, or slot==DIGITS-1 and udf. Otherwise it is inactive.
- Polarity: seg/dp are inverted when SEG_ACTIVE_LOW=1. an is inverted when AN_ACTIVE_LOW=1.
- Reset mid-scan: all state returns to reset values on that edge. The shadow is lost, and a fresh latch is required.

Decomposition:
- Shared package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high a..g)
  - slot width function clog2
- Sub-module bcd_to_seg7: combinational 4-bit -> 7-bit active-high decoder. Instantiated once on the slot-muxed digit. Polarity is applied in the top-level output register.

Test Plan:
1. DIGITS=4, PRESCALE=4, latch bcd_in=16'h1234, en=1 -> an cycles digit 0,1,2,3 every 4 clk. seg shows 4,3,2,1 with 1-cycle lag. frame_tick fires every 16 clk.
2. latch 16'h0007, blank_lz=1 -> only digit 0 anode ever active, showing 7. With blank_lz=0, digits 1-3 show "0". With 16'h0000 and blank_lz=1 -> digit 0 shows "0".
3. sup_in pulse (FLAG_HOLD=2) -> dp lit during slot 0 for exactly 2 frames, then off. A second pulse after 1 frame extends it to 3 frames total.
4. sup_in and inf_in same cycle -> dp lit in slot 0 and in slot 3 of the following frames. Code 4'hA in digit 2 shows g only.
5. en=0 mid-frame at slot 2 -> an/seg/dp inactive next cycle. en=1 resumes at slot 2 with the same prescaler count. A latch while en=0 is still captured.
6. rst_n=0 during the ovf hold with shadow=16'h9999 -> next cycle shows all outputs inactive, shadow=0, dp off. After release, the first frame shows "0" in slot 0 (blank_lz=1).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path.
// Segment patterns are active-high, bit 0 = a .. bit 6 = g.
// clog2 sizes counters and slot indices (never returns less than 1).
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high output.
//   bcd : 4-bit code; 0-9 decode to digits, 10-15 show a dash
//   seg : segments, bit 0 = a .. bit 6 = g
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver for a chain of BCD counter digits.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : scan enable; 0 blanks the display and freezes the scan
//   latch       : capture bcd_in into the shadow register
//   bcd_in      : DIGITS BCD digits, digit 0 in [3:0]
//   sup_in      : carry pulse, lights dp on digit 0 for FLAG_HOLD frames
//   inf_in      : borrow pulse, lights dp on digit DIGITS-1 for FLAG_HOLD frames
//   blank_lz    : suppress leading zeros (digit 0 always shown)
//   seg, dp, an : registered display outputs, polarity set by parameters
//   frame_tick  : one-cycle pulse when the slot wraps back to digit 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 1000,
  parameter int unsigned FLAG_HOLD      = 64,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  latch,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  sup_in,
  input  logic                  inf_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int unsigned SW = clog2(DIGITS);
  localparam int unsigned PW = clog2(PRESCALE);
  localparam int unsigned HW = clog2(FLAG_HOLD + 1);

  localparam logic [6:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       presc;
  logic [SW-1:0]       slot;
  logic                ovf, udf;
  logic [HW-1:0]       ovf_hold, udf_hold;

  logic [DIGITS-1:0]   lz;
  logic [3:0]          digit;
  logic [6:0]          seg_dec;
  logic                blank;
  logic [DIGITS-1:0]   an_hot;
  logic                dp_hi;

  // lz[i] = digits i..DIGITS-1 are all zero
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (shadow[4*DIGITS-1 -: 4] == 4'd0);
    for (int unsigned k = 1; k < DIGITS; k++) begin
      lz[DIGITS-1-k] = lz[DIGITS-k] && (shadow[4*(DIGITS-1-k) +: 4] == 4'd0);
    end
  end

  always_comb begin
    digit  = shadow[{slot, 2'b00} +: 4];
    blank  = blank_lz && (slot != '0) && lz[slot];
    an_hot = DIGITS'(1) << slot;
    dp_hi  = ((slot == '0) && ovf) || ((slot == SW'(DIGITS-1)) && udf);
  end

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow     <= '0;
      presc      <= '0;
      slot       <= '0;
      frame_tick <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      ovf_hold   <= '0;
      udf_hold   <= '0;
      seg        <= SEG_OFF ^ SEG_INV;
      dp         <= SEG_INV[0];
      an         <= AN_INV;
    end else begin
      if (latch) shadow <= bcd_in;

      frame_tick <= 1'b0;
      if (en) begin
        if (presc == PW'(PRESCALE-1)) begin
          presc <= '0;
          if (slot == SW'(DIGITS-1)) begin
            slot       <= '0;
            frame_tick <= 1'b1;
          end else begin
            slot <= slot + SW'(1);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end

      // Hold counters count frame_tick pulses; a fresh pulse reloads and
      // takes priority over a coincident decrement.
      if (sup_in) begin
        ovf_hold <= HW'(FLAG_HOLD);
        ovf      <= 1'b1;
      end else if (frame_tick && (ovf_hold != '0)) begin
        ovf_hold <= ovf_hold - HW'(1);
        if (ovf_hold == HW'(1)) ovf <= 1'b0;
      end

      if (inf_in) begin
        udf_hold <= HW'(FLAG_HOLD);
        udf      <= 1'b1;
      end else if (frame_tick && (udf_hold != '0)) begin
        udf_hold <= udf_hold - HW'(1);
        if (udf_hold == HW'(1)) udf <= 1'b0;
      end

      if (en) begin
        seg <= (blank ? SEG_OFF : seg_dec) ^ SEG_INV;
        an  <= (blank ? '0 : an_hot) ^ AN_INV;
        dp  <= dp_hi ^ SEG_INV[0];
      end else begin
        seg <= SEG_OFF ^ SEG_INV;
        an  <= AN_INV;
        dp  <= SEG_INV[0];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, PRESCALE=4, FLAG_HOLD=2,
// active-low seg/dp/an). A cycle model predicts every output; directed
// sequences add hand-computed literal checks.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int P  = 4;
  localparam int FH = 2;

  logic        clk = 1'b0;
  logic        rst_n, en, latch, sup_in, inf_in, blank_lz;
  logic [15:0] bcd_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(
    .DIGITS(4), .PRESCALE(4), .FLAG_HOLD(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .latch(latch), .bcd_in(bcd_in),
    .sup_in(sup_in), .inf_in(inf_in), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  string letters [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg",
                          "g", "g", "g", "g", "g", "g"};

  function automatic logic [6:0] pattern(input int unsigned d);
    string s;
    logic [6:0] r;
    r = '0;
    s = letters[d];
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  int unsigned m_dig [D];
  int          pos, ovf_f, udf_f, slot_m;
  bit          model_ok = 0;
  bit          blank_m, lit_m, prev_ft;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_ft;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) m_dig[k] = 0;
      pos = 0; ovf_f = 0; udf_f = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
      model_ok = 1;
    end else begin
      slot_m = pos / P;
      if (en) begin
        blank_m = 0;
        if (blank_lz && slot_m > 0) begin
          blank_m = 1;
          for (int j = slot_m; j < D; j++) if (m_dig[j] != 0) blank_m = 0;
        end
        lit_m   = (slot_m == 0 && ovf_f > 0) || (slot_m == D-1 && udf_f > 0);
        exp_an  = blank_m ? 4'hF : ~(4'b0001 << slot_m);
        exp_seg = blank_m ? 7'h7F : ~pattern(m_dig[slot_m]);
        exp_dp  = ~lit_m;
      end else begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      prev_ft = exp_ft;
      exp_ft  = en && (pos == D*P-1);
      if (sup_in) ovf_f = FH; else if (prev_ft && ovf_f > 0) ovf_f--;
      if (inf_in) udf_f = FH; else if (prev_ft && udf_f > 0) udf_f--;
      if (en) pos = (pos + 1) % (D*P);
      if (latch) for (int k = 0; k < D; k++) m_dig[k] = bcd_in[4*k +: 4];
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_an", 32'(an), 32'(exp_an));
      check("model_seg", 32'(seg), 32'(exp_seg));
      check("model_dp", 32'(dp), 32'(exp_dp));
      check("model_tick", 32'(frame_tick), 32'(exp_ft));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle of a frame (frame_tick high).
  task automatic wait_ft();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1;
    end
    check("frame_tick_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_latch(input logic [15:0] v);
    latch = 1'b1; bcd_in = v;
    step(1);
    latch = 1'b0;
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; en = 1'b0; latch = 1'b0; sup_in = 1'b0; inf_in = 1'b0;
    blank_lz = 1'b0; bcd_in = '0;
    step(2);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_tick", 32'(frame_tick), 32'd0);
    step(1);
    rst_n = 1'b1;

    // 1: basic scan of 1234
    en = 1'b1;
    do_latch(16'h1234);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_tick) cnt++;
    end
    check("tick_per_64", 32'(cnt), 32'd4);
    wait_ft(); step(1);
    check("s1_an_d0", 32'(an), 32'hE);
    check("s1_seg_4", 32'(seg), 32'h19);
    step(4);
    check("s1_an_d1", 32'(an), 32'hD);
    check("s1_seg_3", 32'(seg), 32'h30);

    // 2: leading-zero blanking
    blank_lz = 1'b1;
    do_latch(16'h0007);
    step(20);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (an != 4'hF && an != 4'hE) cnt++;
    end
    check("lz_other_anodes", 32'(cnt), 32'd0);
    wait_ft(); step(1);
    check("lz_seg_7", 32'(seg), 32'h78);
    blank_lz = 1'b0;
    step(32);
    do_latch(16'h0000);
    blank_lz = 1'b1;
    step(20);
    wait_ft(); step(1);
    check("zero_an_d0", 32'(an), 32'hE);
    check("zero_seg_0", 32'(seg), 32'h40);
    step(4);
    check("zero_d1_blank", 32'(an), 32'hF);

    // 3: overflow hold, single pulse then re-pulse after one frame
    blank_lz = 1'b0;
    do_latch(16'h1234);
    wait_ft();
    sup_in = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      sup_in = 1'b0;
      if (dp == 1'b0) cnt++;
    end
    check("ovf_lit_single", 32'(cnt), 32'd8);
    wait_ft();
    sup_in = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      sup_in = (i == 16);
      if (dp == 1'b0) cnt++;
    end
    check("ovf_lit_extended", 32'(cnt), 32'd12);

    // 4: simultaneous carry and borrow, dash code
    do_latch(16'h0A00);
    wait_ft();
    sup_in = 1'b1; inf_in = 1'b1;
    step(1);
    sup_in = 1'b0; inf_in = 1'b0;
    step(8);
    check("dash_seg", 32'(seg), 32'h3F);
    step(4);
    check("udf_an_d3", 32'(an), 32'h7);
    check("udf_dp", 32'(dp), 32'd0);
    step(80);

    // 5: pause mid-frame at slot 2, latch while paused
    do_latch(16'h1234);
    wait_ft(); step(9);
    en = 1'b0;
    step(1);
    check("pause_an", 32'(an), 32'hF);
    do_latch(16'h5678);
    step(3);
    check("pause_seg", 32'(seg), 32'h7F);
    check("pause_dp", 32'(dp), 32'd1);
    en = 1'b1;
    step(1);
    check("resume_an_d2", 32'(an), 32'hB);
    check("resume_seg_6", 32'(seg), 32'h02);
    step(40);

    // 6: reset during overflow hold
    blank_lz = 1'b1;
    do_latch(16'h9999);
    wait_ft();
    sup_in = 1'b1;
    step(1);
    sup_in = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(1);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp", 32'(dp), 32'd1);
    rst_n = 1'b1;
    wait_ft(); step(1);
    check("post_an_d0", 32'(an), 32'hE);
    check("post_seg_0", 32'(seg), 32'h40);
    check("post_dp_off", 32'(dp), 32'd1);
    step(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
